// File: rtl/program_counter_ras.sv
// Fetch-side program counter with priority redirect (trap/ret/call/jump/branch)
// and a circular return-address stack that keeps the newest RAS_DEPTH entries.
module program_counter_ras #(
   parameter int unsigned PC_WIDTH     = 16,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_00F0,
   parameter int unsigned RAS_DEPTH    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             run,
   input  logic                             trap,
   input  logic                             ret,
   input  logic                             call,
   input  logic                             jump,
   input  logic [PC_WIDTH-1:0]              jump_address,
   input  logic                             branch,
   input  logic [PC_WIDTH-1:0]              branch_offset,
   output logic [PC_WIDTH-1:0]              pc,
   output logic [$clog2(RAS_DEPTH):0]       ras_count,
   output logic                             ras_overflow,
   output logic                             ras_underflow
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(RESET_VECTOR);
   localparam logic [PC_WIDTH-1:0] PC_TRAP  = PC_WIDTH'(TRAP_VECTOR);
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RAS_DEPTH);

   typedef enum logic [2:0] {
      ACT_INC,
      ACT_TRAP,
      ACT_RET,
      ACT_CALL,
      ACT_JUMP,
      ACT_BRANCH
   } action_e;

   action_e                 action;
   logic [PC_WIDTH-1:0]     ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]        ras_ptr;

   logic [PC_WIDTH-1:0]     pc_inc;
   logic [PC_WIDTH-1:0]     pc_branch;
   logic                    ras_full;
   logic                    ras_empty;

   logic [PC_WIDTH-1:0]     pc_nxt;
   logic [PTR_W-1:0]        ptr_nxt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic                    ovf_nxt;
   logic                    udf_nxt;
   logic                    push_en;

   assign pc_inc    = PC_WIDTH'(pc + PC_WIDTH'(1));
   assign pc_branch = PC_WIDTH'(pc + branch_offset);
   assign ras_full  = (ras_count == CNT_FULL);
   assign ras_empty = (ras_count == CNT_W'(0));

   // Fixed-priority selection; lower-priority requests are fully suppressed
   always_comb begin
      action = ACT_INC;
      if (trap) begin
         action = ACT_TRAP;
      end else if (ret) begin
         action = ACT_RET;
      end else if (call) begin
         action = ACT_CALL;
      end else if (jump) begin
         action = ACT_JUMP;
      end else if (branch) begin
         action = ACT_BRANCH;
      end
   end

   // Next-state for pc, stack pointer, count and sticky flags
   always_comb begin
      pc_nxt  = pc;
      ptr_nxt = ras_ptr;
      cnt_nxt = ras_count;
      ovf_nxt = ras_overflow;
      udf_nxt = ras_underflow;
      push_en = 1'b0;
      if (run) begin
         unique case (action)
            ACT_TRAP: begin
               pc_nxt = PC_TRAP;
            end
            ACT_RET: begin
               if (ras_empty) begin
                  pc_nxt  = pc_inc;
                  udf_nxt = 1'b1;
               end else begin
                  pc_nxt  = ras_mem[ras_ptr];
                  ptr_nxt = PTR_W'(ras_ptr - PTR_W'(1));
                  cnt_nxt = CNT_W'(ras_count - CNT_W'(1));
               end
            end
            ACT_CALL: begin
               // When full, pointer+1 lands on the oldest entry and overwrites it
               pc_nxt  = jump_address;
               push_en = 1'b1;
               ptr_nxt = PTR_W'(ras_ptr + PTR_W'(1));
               if (ras_full) begin
                  ovf_nxt = 1'b1;
               end else begin
                  cnt_nxt = CNT_W'(ras_count + CNT_W'(1));
               end
            end
            ACT_JUMP: begin
               pc_nxt = jump_address;
            end
            ACT_BRANCH: begin
               pc_nxt = pc_branch;
            end
            default: begin
               pc_nxt = pc_inc;
            end
         endcase
      end
   end

   // Architectural state
   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= PC_RESET;
         ras_ptr       <= '0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         pc            <= pc_nxt;
         ras_ptr       <= ptr_nxt;
         ras_count     <= cnt_nxt;
         ras_overflow  <= ovf_nxt;
         ras_underflow <= udf_nxt;
      end
   end

   // Stack storage carries no reset; entries beyond ras_count are never read
   always_ff @(posedge clk) begin
      if (!rst && push_en) begin
         ras_mem[ptr_nxt] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_program_counter_ras.sv
// Directed bench for program_counter_ras with hand-computed expected pc/RAS values.
module tb_program_counter_ras;

   logic        clk;
   logic        rst;
   logic        run;
   logic        trap;
   logic        ret;
   logic        call;
   logic        jump;
   logic [15:0] jump_address;
   logic        branch;
   logic [15:0] branch_offset;
   logic [15:0] pc;
   logic [2:0]  ras_count;
   logic        ras_overflow;
   logic        ras_underflow;

   int n_cmp;
   int n_bad;

   program_counter_ras #(
      .PC_WIDTH     (16),
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_00F0),
      .RAS_DEPTH    (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .trap          (trap),
      .ret           (ret),
      .call          (call),
      .jump          (jump),
      .jump_address  (jump_address),
      .branch        (branch),
      .branch_offset (branch_offset),
      .pc            (pc),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of controls, then sample 1ns after the edge
   task automatic step(input logic t, input logic r, input logic c, input logic j,
                       input logic b, input logic [15:0] addr, input logic [15:0] off);
      trap = t; ret = r; call = c; jump = j; branch = b;
      jump_address = addr; branch_offset = off;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic do_call(input logic [15:0] addr);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, addr, 16'h0);
   endtask

   task automatic do_ret();
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
   endtask

   task automatic do_jump(input logic [15:0] addr);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, addr, 16'h0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1; run = 1'b0;
      trap = 1'b0; ret = 1'b0; call = 1'b0; jump = 1'b0; branch = 1'b0;
      jump_address = '0; branch_offset = '0;

      idle();
      idle();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_cnt", 32'(ras_count), 32'd0);
      chk("rst_ovf", 32'(ras_overflow), 32'd0);
      chk("rst_udf", 32'(ras_underflow), 32'd0);

      rst = 1'b0; run = 1'b1;
      idle(); chk("inc1", 32'(pc), 32'h1);
      idle(); chk("inc2", 32'(pc), 32'h2);
      idle(); chk("inc3", 32'(pc), 32'h3);

      run = 1'b0;
      do_jump(16'h1234); chk("hold1", 32'(pc), 32'h3);
      do_call(16'h4321); chk("hold2", 32'(pc), 32'h3);
      chk("hold_cnt", 32'(ras_count), 32'd0);
      do_ret(); chk("hold_udf", 32'(ras_underflow), 32'd0);
      run = 1'b1;

      do_jump(16'hFFFF); chk("jump_ffff", 32'(pc), 32'hFFFF);
      idle(); chk("wrap", 32'(pc), 32'h0);
      do_jump(16'h0010); chk("jump_10", 32'(pc), 32'h10);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'hFFFC);
      chk("branch_neg", 32'(pc), 32'h0C);

      do_jump(16'h0005); chk("jump_5", 32'(pc), 32'h5);
      do_call(16'h0100); chk("call1_pc", 32'(pc), 32'h100);
      chk("call1_cnt", 32'(ras_count), 32'd1);
      do_call(16'h0200); chk("call2_pc", 32'(pc), 32'h200);
      chk("call2_cnt", 32'(ras_count), 32'd2);
      do_ret(); chk("ret1_pc", 32'(pc), 32'h101);
      chk("ret1_cnt", 32'(ras_count), 32'd1);
      do_ret(); chk("ret2_pc", 32'(pc), 32'h6);
      chk("ret2_cnt", 32'(ras_count), 32'd0);
      chk("nest_ovf", 32'(ras_overflow), 32'd0);
      chk("nest_udf", 32'(ras_underflow), 32'd0);

      // Five calls from 0x0006,0x1000,0x2000,0x3000,0x4000
      do_call(16'h1000);
      do_call(16'h2000);
      do_call(16'h3000);
      do_call(16'h4000);
      chk("full_cnt", 32'(ras_count), 32'd4);
      chk("full_no_ovf", 32'(ras_overflow), 32'd0);
      do_call(16'h5000);
      chk("ovf_pc", 32'(pc), 32'h5000);
      chk("ovf_cnt", 32'(ras_count), 32'd4);
      chk("ovf_flag", 32'(ras_overflow), 32'd1);
      do_ret(); chk("oret1", 32'(pc), 32'h4001);
      do_ret(); chk("oret2", 32'(pc), 32'h3001);
      do_ret(); chk("oret3", 32'(pc), 32'h2001);
      do_ret(); chk("oret4", 32'(pc), 32'h1001);
      chk("oret_cnt", 32'(ras_count), 32'd0);
      chk("oret_no_udf", 32'(ras_underflow), 32'd0);
      do_ret(); chk("udf_pc", 32'(pc), 32'h1002);
      chk("udf_flag", 32'(ras_underflow), 32'd1);
      chk("udf_cnt", 32'(ras_count), 32'd0);

      do_call(16'h0300); chk("pcall_cnt", 32'(ras_count), 32'd1);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0777, 16'h0);
      chk("trap_pc", 32'(pc), 32'hF0);
      chk("trap_cnt", 32'(ras_count), 32'd1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0888, 16'h0);
      chk("retcall_pc", 32'(pc), 32'h1003);
      chk("retcall_cnt", 32'(ras_count), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0010);
      chk("branch_pos", 32'(pc), 32'h1013);

      do_call(16'h0400);
      do_call(16'h0500);
      chk("pre_rst_cnt", 32'(ras_count), 32'd2);
      rst = 1'b1;
      do_call(16'h0600);
      rst = 1'b0;
      chk("mid_rst_pc", 32'(pc), 32'h0);
      chk("mid_rst_cnt", 32'(ras_count), 32'd0);
      chk("mid_rst_ovf", 32'(ras_overflow), 32'd0);
      chk("mid_rst_udf", 32'(ras_underflow), 32'd0);
      do_ret();
      chk("post_rst_pc", 32'(pc), 32'h1);
      chk("post_rst_udf", 32'(ras_underflow), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/program_counter_ras.md
Name: program_counter_ras

Overview:
- Parametrised next-generation program counter for the RISC-V core.
- Generalises run/jump sequencing with configurable width and reset vector, PC-relative branch, trap redirect, and a hardware return-address stack (RAS) for call/return.
- Sits at the front of fetch. `pc` addresses instruction memory directly (word-addressed, step 1).
- Control inputs come from decode/execute in the same cycle.

Parameters:
- PC_WIDTH, 16, width of pc and all address inputs.
- RESET_VECTOR, 0, pc value loaded on reset.
- TRAP_VECTOR, 16'h00F0, pc value loaded on trap (truncated to PC_WIDTH).
- RAS_DEPTH, 4, number of return-address entries (power of two, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  advance enable; when 0, all state holds.
- trap  input  1  redirect to TRAP_VECTOR.
- ret  input  1  return: pop RAS into pc.
- call  input  1  call: push pc+1, go to jump_address.
- jump  input  1  absolute jump to jump_address.
- jump_address  input  PC_WIDTH  absolute target for jump/call.
- branch  input  1  taken PC-relative branch.
- branch_offset  input  PC_WIDTH  two's-complement offset added to pc.
- pc  output  PC_WIDTH  current program counter (registered).
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
- ras_overflow  output  1  sticky: a push occurred while full.
- ras_underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (synchronous, active-high, overrides everything) sets:
  - pc = RESET_VECTOR
  - ras_count = 0
  - RAS pointer = 0
  - ras_overflow = 0, ras_underflow = 0
  - RAS entry contents are don't-care.
- The first post-reset edge with run=1 produces the first redirect or increment. Latency from control input to pc is one cycle. pc is purely registered, with no combinational path from inputs to outputs.
- run=0: pc, RAS, count and flags hold regardless of other inputs.
- run=1: exactly one action is taken, by fixed priority:
  1. trap: pc <= TRAP_VECTOR. RAS untouched.
  2. ret:
     - If ras_count>0: pc <= top entry; count-1.
     - If empty: pc <= pc+1; ras_underflow <= 1; count stays 0.
  3. call: push (pc+1 mod 2^PC_WIDTH); pc <= jump_address.
     - If not full: count+1.
     - If full: the push overwrites the oldest entry (circular buffer); count stays RAS_DEPTH; ras_overflow <= 1.
  4. jump: pc <= jump_address.
  5. branch: pc <= pc + branch_offset, modulo 2^PC_WIDTH (signed wrap, no saturation).
  6. none: pc <= pc + 1. Wraps from all-ones to 0.
- Simultaneous asserted inputs: lower-priority actions are fully suppressed. Examples:
  - trap+call: no push.
  - ret+call: pop only, no push.
- RAS organisation:
  - Circular array indexed by a top pointer of $clog2(RAS_DEPTH) bits. Push writes at pointer+1 then advances.
  - Pop reads at the pointer then decrements.
  - Count saturates at RAS_DEPTH and is floored at 0.
- Sticky flags are set only as above and are cleared only by rst.
- Reset mid-sequence (e.g. during a call chain) discards all RAS state; the next ret underflows.

Test Plan:
- Reset/increment: rst=1 for 2 cycles, then run=1 with no controls for 3 cycles → pc = 0,1,2,3. Hold run=0 for 2 cycles → pc stays 3.
- Wrap and branch (PC_WIDTH=16):
  - Force pc to 16'hFFFF via jump; next idle cycle → pc = 0.
  - At pc=0x0010, branch with offset 16'hFFFC → pc = 0x000C.
- Call/return nesting: at pc=0x0005 call 0x0100; at 0x0100 call 0x0200; ret → pc = 0x0101; ret → pc = 0x0006. ras_count goes 1, 2, 1, 0; no flags set.
- Overflow (RAS_DEPTH=4): 5 consecutive calls from pcs A0..A4 → ras_count = 4, ras_overflow = 1. Then 4 rets → return to A4+1, A3+1, A2+1, A1+1. A 5th ret → pc+1, ras_underflow = 1.
- Priority: assert trap+call+jump together → pc = TRAP_VECTOR, ras_count unchanged. Assert ret+call with count=1 → pc = popped value, count = 0.
- Reset mid-operation: after 2 calls, rst=1 for one cycle → pc = RESET_VECTOR, ras_count = 0, flags = 0. Next ret → pc = RESET_VECTOR+1, ras_underflow = 1.
